// File: rtl/shift_add_multiplier.sv
// Sequential unsigned 8x8 shift-add multiplier, one partial product per clock.
// It includes the shared 8-bit ripple-carry adder it drives each iteration.

// 8-bit ripple-carry adder built from a chain of full adders.
module adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[8];

endmodule

// Multiplier top: IDLE -> BUSY (8 iterations) -> DONE (one cycle) -> IDLE or BUSY.
module shift_add_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  m_q, m_d;        // multiplicand
  logic [7:0]  a_q, a_d;        // accumulator (high half)
  logic [7:0]  q_q, q_d;        // multiplier, becomes the low half
  logic        c_q, c_d;        // carry out of the last partial-product add
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] product_q, product_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [7:0]  add_sum;
  logic        add_cout;
  logic [7:0]  step_s;
  logic        step_c;
  logic [7:0]  shift_a;
  logic [7:0]  shift_q;

  adder u_adder (
    .a    (a_q),
    .b    (m_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Partial product: add M only when the current multiplier bit is set, then shift {C,S,Q} right.
  always_comb begin
    step_s  = a_q;
    step_c  = 1'b0;
    if (q_q[0]) begin
      step_s = add_sum;
      step_c = add_cout;
    end
    shift_a = {step_c, step_s[7:1]};
    shift_q = {step_s[0], q_q[7:1]};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
        if (start) begin
          m_d     = a;
          q_d     = b;
          a_d     = 8'h00;
          c_d     = 1'b0;
          cnt_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = StBusy;
        end
      end
      StBusy: begin
        a_d   = shift_a;
        q_d   = shift_q;
        c_d   = step_c;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          product_d = {shift_a, shift_q};
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = StDone;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      m_q       <= 8'h00;
      a_q       <= 8'h00;
      q_q       <= 8'h00;
      c_q       <= 1'b0;
      cnt_q     <= 3'd0;
      product_q <= 16'h0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // The saved carry is always the bit shifted into A[7], so none is ever lost.
  carry_in_msb_a: assert property (@(posedge clk) disable iff (!rst_n) c_q == a_q[7]);

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier; reference result is plain a*b.
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks;
  int failures;

  shift_add_multiplier dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: one start pulse, then watch until done (bounded).
  task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b,
                        output logic [15:0] prod, output int lat, output int busy_cnt,
                        output bit timed_out);
    @(negedge clk);
    a = op_a;
    b = op_b;
    start = 1'b1;
    lat = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy === 1'b1) busy_cnt++;
    end while (done !== 1'b1 && lat < 30);
    timed_out = (done !== 1'b1);
    prod = product;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      failures++;
      $display("FAIL reset_state got busy=%b done=%b product=%h exp 0 0 0000", busy, done, product);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    logic [15:0] p;
    int lat, bc;
    bit to;
    run_op(8'd13, 8'd11, p, lat, bc, to);
    checks++;
    if (to || p !== 16'h008F) begin
      failures++;
      $display("FAIL basic_product got=%h exp=008f timeout=%0d", p, to);
    end
    checks++;
    if (lat != 9) begin
      failures++;
      $display("FAIL basic_latency got=%0d exp=9", lat);
    end
    checks++;
    if (bc != 8) begin
      failures++;
      $display("FAIL basic_busy_cycles got=%0d exp=8", bc);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== 16'h008F) begin
      failures++;
      $display("FAIL basic_done_pulse got done=%b busy=%b product=%h exp 0 0 008f",
               done, busy, product);
    end
  endtask

  task automatic test_carry();
    logic [15:0] p;
    int lat, bc;
    bit to;
    run_op(8'hFF, 8'hFF, p, lat, bc, to);
    checks++;
    if (to || p !== 16'hFE01 || lat != 9) begin
      failures++;
      $display("FAIL carry_ff_ff got=%h lat=%0d exp=fe01 lat=9", p, lat);
    end
  endtask

  task automatic test_hold();
    logic [15:0] p;
    int lat, bc;
    bit to;
    int held_bad;
    run_op(8'h80, 8'h02, p, lat, bc, to);
    checks++;
    if (to || p !== 16'h0100) begin
      failures++;
      $display("FAIL hold_first got=%h exp=0100", p);
    end
    @(negedge clk);
    a = 8'h00;
    b = 8'hA5;
    start = 1'b1;
    lat = 0;
    held_bad = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (done !== 1'b1 && product !== 16'h0100) held_bad++;
    end while (done !== 1'b1 && lat < 30);
    checks++;
    if (held_bad != 0) begin
      failures++;
      $display("FAIL hold_during_busy got %0d cycles changed exp 0 (value 0100)", held_bad);
    end
    checks++;
    if (done !== 1'b1 || product !== 16'h0000 || lat != 9) begin
      failures++;
      $display("FAIL hold_second got=%h lat=%0d exp=0000 lat=9", product, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    a = 8'd3;
    b = 8'd5;
    start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (done !== 1'b1) begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
    end while (done !== 1'b1 && lat < 30);
    checks++;
    if (done !== 1'b1 || product !== 16'h000F || lat != 9) begin
      failures++;
      $display("FAIL b2b_first got=%h lat=%0d exp=000f lat=9", product, lat);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_busy_in_done got=%b exp=0", busy);
    end
    a = 8'd7;
    b = 8'd9;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL b2b_no_bubble got busy=%b exp=1", busy);
        end
      end
    end while (done !== 1'b1 && lat < 30);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || product !== 16'h003F || lat != 9) begin
      failures++;
      $display("FAIL b2b_second got=%h lat=%0d exp=003f lat=9", product, lat);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_return_idle got done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] p;
    int lat, bc;
    bit to;
    @(negedge clk);
    a = 8'd200;
    b = 8'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mid got busy=%b done=%b product=%h exp 0 0 0000", busy, done, product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_idle got busy=%b done=%b exp 0 0", busy, done);
    end
    run_op(8'd200, 8'd100, p, lat, bc, to);
    checks++;
    if (to || p !== 16'h4E20 || lat != 9) begin
      failures++;
      $display("FAIL reset_mid_rerun got=%h lat=%0d exp=4e20 lat=9", p, lat);
    end
  endtask

  // Back-to-back stream of corner and random operands, each result checked against a*b.
  task automatic test_random();
    int n_ops;
    int lat;
    logic [7:0]  ra, rb;
    logic [15:0] exp_p;
    n_ops = 300;
    @(negedge clk);
    ra = 8'h00;
    rb = 8'h00;
    a = ra;
    b = rb;
    start = 1'b1;
    exp_p = 16'(ra) * 16'(rb);
    for (int i = 0; i < n_ops; i++) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (done !== 1'b1 && lat < 30);
      checks++;
      if (done !== 1'b1 || product !== exp_p) begin
        failures++;
        $display("FAIL random_product op=%0d got=%h exp=%h", i, product, exp_p);
      end
      checks++;
      if (lat != 9) begin
        failures++;
        $display("FAIL random_latency op=%0d got=%0d exp=9", i, lat);
      end
      case (i)
        0:       begin ra = 8'hFF; rb = 8'h01; end
        1:       begin ra = 8'h01; rb = 8'hFF; end
        2:       begin ra = 8'hFF; rb = 8'h00; end
        default: begin ra = 8'($urandom); rb = 8'($urandom); end
      endcase
      a = ra;
      b = rb;
      exp_p = 16'(ra) * 16'(rb);
      if (i == n_ops - 1) start = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_carry();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
